// File: rtl/load_store_buffer_if.sv
// Load/store buffer bus: RS mission intake, ROB commit/flush,
// CDB broadcast and the byte-wide memory port.
interface load_store_buffer_if;
  logic        ls_mission;
  logic [3:0]  ls_ins_rnm;
  logic [5:0]  ls_op_type;
  logic [31:0] ls_addr_offset;
  logic [31:0] ls_ins_rs1;
  logic [31:0] store_ins_rs2;
  logic        lsb_full;
  logic        store_ready;
  logic [3:0]  store_ready_rnm;
  logic        store_commit;
  logic [3:0]  store_commit_rnm;
  logic        flush;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        cdb_flag;
  logic [3:0]  cdb_rename;
  logic [31:0] cdb_value;

  modport master (
    output ls_mission, ls_ins_rnm, ls_op_type,
    output ls_addr_offset, ls_ins_rs1, store_ins_rs2,
    output store_commit, store_commit_rnm, flush, mem_din,
    input  lsb_full, store_ready, store_ready_rnm,
    input  mem_dout, mem_a, mem_wr,
    input  cdb_flag, cdb_rename, cdb_value
  );

  modport slave (
    input  ls_mission, ls_ins_rnm, ls_op_type,
    input  ls_addr_offset, ls_ins_rs1, store_ins_rs2,
    input  store_commit, store_commit_rnm, flush, mem_din,
    output lsb_full, store_ready, store_ready_rnm,
    output mem_dout, mem_a, mem_wr,
    output cdb_flag, cdb_rename, cdb_value
  );
endinterface

// File: rtl/load_store_buffer.sv
// In-order load/store queue: byte-serial memory access,
// loads broadcast on the CDB, stores wait for ROB commit.
module load_store_buffer #(
  parameter int LSB_SIZE = 8,
  parameter int PTR_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rdy,
  load_store_buffer_if.slave bus
);

  localparam logic [5:0] LB  = 6'd11;
  localparam logic [5:0] LH  = 6'd12;
  localparam logic [5:0] LW  = 6'd13;
  localparam logic [5:0] LBU = 6'd14;
  localparam logic [5:0] LHU = 6'd15;
  localparam logic [5:0] SB  = 6'd16;
  localparam logic [5:0] SH  = 6'd17;
  localparam logic [5:0] SW  = 6'd18;

  localparam logic [PTR_W:0] SIZE   = (PTR_W+1)'(LSB_SIZE);
  localparam logic [PTR_W:0] FULL_T = (PTR_W+1)'(LSB_SIZE-2);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, STORE} state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic        cmt;
  } ent_t;

  function automatic logic is_st(input logic [5:0] o);
    return (o >= SB) && (o <= SW);
  endfunction

  ent_t             q [LSB_SIZE];
  ent_t             h;
  logic [PTR_W-1:0] head, tail, pk;
  logic [PTR_W:0]   cnt, run;
  logic [LSB_SIZE-1:0] busy;
  state_t           st, st_nxt;
  logic [2:0]       idx, nb;
  logic [1:0]       bi;
  logic [31:0]      ld, ext;
  logic             cap, sr_q, stop;
  logic [3:0]       sr_tag;
  logic             h_ld, last, enq, pop_st, pop_ld, pop;

  assign h    = q[head];
  assign h_ld = (h.op >= LB) && (h.op <= LHU);
  assign last = (idx == nb - 3'd1);
  assign bi   = idx[1:0] - 2'd1;

  always_comb begin
    nb = 3'd1;
    case (h.op)
      LH, LHU, SH: nb = 3'd2;
      LW, SW:      nb = 3'd4;
      default:     nb = 3'd1;
    endcase
  end

  assign enq    = rdy && bus.ls_mission && !bus.flush
               && (cnt != SIZE);
  assign pop_st = rdy && (st == STORE) && last;
  assign pop_ld = rdy && !bus.flush && (st == DONE);
  assign pop    = pop_st || pop_ld;

  always_comb begin
    busy = '0;
    for (int i = 0; i < LSB_SIZE; i++)
      busy[i] = {1'b0, PTR_W'(PTR_W'(i) - head)} < cnt;
  end

  // flush keeps only the committed-store prefix at head
  always_comb begin
    run  = '0;
    stop = 1'b0;
    pk   = '0;
    for (int k = 0; k < LSB_SIZE; k++) begin
      pk = head + PTR_W'(k);
      if (!stop && busy[pk] && q[pk].cmt)
        run = run + (PTR_W+1)'(1);
      else
        stop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < LSB_SIZE; i++)
        q[i] <= '0;
    end else if (rdy) begin
      for (int i = 0; i < LSB_SIZE; i++)
        if (bus.store_commit && busy[i] && is_st(q[i].op)
            && q[i].tag == bus.store_commit_rnm)
          q[i].cmt <= 1'b1;
      if (enq) begin
        q[tail].op   <= bus.ls_op_type;
        q[tail].tag  <= bus.ls_ins_rnm;
        q[tail].addr <= bus.ls_ins_rs1 + bus.ls_addr_offset;
        q[tail].data <= bus.store_ins_rs2;
        q[tail].cmt  <= 1'b0;
      end
      if (bus.flush) begin
        head <= head + PTR_W'(pop_st);
        tail <= head + run[PTR_W-1:0];
        cnt  <= run - (PTR_W+1)'(pop_st);
      end else begin
        head <= head + PTR_W'(pop);
        tail <= tail + PTR_W'(enq);
        cnt  <= cnt + (PTR_W+1)'(enq)
              - (PTR_W+1)'(pop);
      end
    end
  end

  // read data lags the address by one cycle, even across stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      idx    <= '0;
      ld     <= '0;
      cap    <= 1'b0;
      sr_q   <= 1'b0;
      sr_tag <= '0;
    end else begin
      cap    <= rdy;
      sr_q   <= enq && is_st(bus.ls_op_type);
      sr_tag <= bus.ls_ins_rnm;
      if (st == LOAD && cap && idx != 3'd0)
        ld[{bi, 3'b000} +: 8] <= bus.mem_din;
      if (rdy) begin
        st  <= st_nxt;
        idx <= (st_nxt == st) ? idx + 3'd1 : 3'd0;
      end
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:
        if (cnt != '0) begin
          if (h_ld && !bus.flush) st_nxt = LOAD;
          else if (h.cmt)         st_nxt = STORE;
        end
      LOAD:
        if (bus.flush)      st_nxt = IDLE;
        else if (idx == nb) st_nxt = DONE;
      DONE:  st_nxt = IDLE;
      STORE: if (last) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_comb begin
    ext = ld;
    unique case (1'b1)
      (h.op == LB):  ext = {{24{ld[7]}}, ld[7:0]};
      (h.op == LH):  ext = {{16{ld[15]}}, ld[15:0]};
      (h.op == LBU): ext = {24'd0, ld[7:0]};
      (h.op == LHU): ext = {16'd0, ld[15:0]};
      default:       ext = ld;
    endcase
  end

  always_comb begin
    bus.mem_a      = '0;
    bus.mem_wr     = 1'b0;
    bus.mem_dout   = '0;
    bus.cdb_flag   = 1'b0;
    bus.cdb_rename = '0;
    bus.cdb_value  = '0;
    unique case (st)
      LOAD: bus.mem_a = h.addr + 32'(idx);
      STORE: begin
        bus.mem_a    = h.addr + 32'(idx);
        bus.mem_wr   = rdy;
        bus.mem_dout = h.data[{idx[1:0], 3'b000} +: 8];
      end
      DONE: begin
        bus.cdb_flag = rdy && !bus.flush;
        if (bus.cdb_flag) begin
          bus.cdb_rename = h.tag;
          bus.cdb_value  = ext;
        end
      end
      default: ;
    endcase
  end

  assign bus.lsb_full        = cnt >= FULL_T;
  assign bus.store_ready     = sr_q && rdy && !bus.flush;
  assign bus.store_ready_rnm = sr_q ? sr_tag : 4'd0;

endmodule
